// File: rtl/rec2pol_fq_if.sv
// rec2pol_fq_if: handshake and data bundle between a requester and rec2pol_fq.
// Signal names carry the converter's point of view (_i into it, _o out of it).
// Ports: enable_i, start_i, x_i, y_i (requester -> converter);
//        busy_o, done_o, mod_o, angle_o (converter -> requester).
interface rec2pol_fq_if #(
    parameter int DATA_W  = 32,
    parameter int ANGLE_W = 32
);
    logic                      enable_i;
    logic                      start_i;
    logic signed [DATA_W-1:0]  x_i;
    logic signed [DATA_W-1:0]  y_i;
    logic                      busy_o;
    logic                      done_o;
    logic signed [DATA_W-1:0]  mod_o;
    logic signed [ANGLE_W-1:0] angle_o;

    // Requester side.
    modport master (
        output enable_i, start_i, x_i, y_i,
        input  busy_o, done_o, mod_o, angle_o
    );

    // Converter side.
    modport slave (
        input  enable_i, start_i, x_i, y_i,
        output busy_o, done_o, mod_o, angle_o
    );
endinterface

// File: rtl/rec2pol_fq.sv
// rec2pol_fq: full-quadrant CORDIC rectangular-to-polar converter (modulus + angle in degrees).
// Latency: N_ITER+1 enabled clock edges from accepted start to done; one result per N_ITER+2 cycles.
// Backpressure: none; start is ignored while busy, enable_i=0 freezes every register.
//
// Ports: clk (rising edge), rst (async, active-high), bus (rec2pol_fq_if.slave):
//   enable_i/start_i/x_i/y_i in, busy_o/done_o/mod_o/angle_o out (all outputs registered).
// Build option: define REC2POL_GAINCOMP_EN to scale the modulus by 1/K_cordic in SCALE;
//   without it mod_o is the raw (gain ~1.6468) CORDIC magnitude, saturated.
module rec2pol_fq #(
    parameter int DATA_W     = 32,
    parameter int FRAC_W     = 16,
    parameter int ANGLE_W    = 32,
    parameter int ANGLE_FRAC = 23,
    parameter int N_ITER     = 24
) (
    input  logic         clk,
    input  logic         rst,
    rec2pol_fq_if.slave  bus
);

    // Legal iteration range is 4..30; the atan table covers shifts 0..30.
    if (N_ITER < 4 || N_ITER > 30 || FRAC_W >= DATA_W) begin : g_bad_param
        $error("rec2pol_fq: illegal parameter set");
    end

    localparam int XW     = DATA_W + 2;   // headroom for fold of -2^(DATA_W-1) and CORDIC growth
    localparam int CNT_W  = 5;
    localparam int ATAN_N = 31;

    localparam logic signed [ANGLE_W-1:0] Z180 = ANGLE_W'(longint'(180) << ANGLE_FRAC);

    // atan(2^-i) in degrees, scaled by 2^ANGLE_FRAC and rounded. Evaluated at
    // elaboration only; the Taylor series converges fast for i>=1 (t<=1/2).
    function automatic logic signed [ANGLE_W-1:0] atan_entry(input int i);
        real t, p, s, deg, sc;
        t = 1.0;
        for (int j = 0; j < i; j++) t = t * 0.5;
        if (i == 0) begin
            deg = 45.0;
        end else begin
            s = 0.0;
            p = t;
            for (int k = 0; k < 40; k++) begin
                if (k % 2 == 1) s = s - p / real'(2 * k + 1);
                else            s = s + p / real'(2 * k + 1);
                p = p * t * t;
            end
            deg = s * 180.0 / 3.14159265358979323846;
        end
        sc = 1.0;
        for (int j = 0; j < ANGLE_FRAC; j++) sc = sc * 2.0;
        // real -> integer cast rounds to nearest
        return ANGLE_W'(longint'(deg * sc));
    endfunction

    logic signed [ANGLE_W-1:0] atan_tab [0:ATAN_N-1];
    for (genvar g = 0; g < ATAN_N; g++) begin : g_atan
        localparam logic signed [ANGLE_W-1:0] ENTRY = atan_entry(g);
        assign atan_tab[g] = ENTRY;
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_SCALE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [XW-1:0]       xr_q, xr_d;
    logic signed [XW-1:0]       yr_q, yr_d;
    logic signed [ANGLE_W-1:0]  zr_q, zr_d;
    logic                       zero_q, zero_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic signed [DATA_W-1:0]   mod_q, mod_d;
    logic signed [ANGLE_W-1:0]  angle_q, angle_d;

    logic signed [XW-1:0]       x_ext, y_ext;
    logic signed [ANGLE_W-1:0]  atan_cur;
    logic signed [DATA_W-1:0]   mod_sat;

    // Sign-extend before any negation so the most negative input folds cleanly.
    assign x_ext = XW'(bus.x_i);
    assign y_ext = XW'(bus.y_i);

    always_comb begin
        atan_cur = '0;
        for (int i = 0; i < ATAN_N; i++) begin
            if (cnt_q == CNT_W'(i)) atan_cur = atan_tab[i];
        end
    end

    // ---------------------------------------------------------------
    // Modulus scaling and saturation (evaluated from the final xr).
    // ---------------------------------------------------------------
`ifdef REC2POL_GAINCOMP_EN
    localparam int SCL_W = DATA_W + 19;
    localparam logic signed [SCL_W-1:0] K_Q16   = SCL_W'(39797);   // ~1/1.646760 in Q0.16
    localparam logic signed [SCL_W-1:0] RND_Q16 = SCL_W'(32768);
    logic signed [SCL_W-1:0] prod;
    logic signed [SCL_W-1:0] mag;
    assign prod = SCL_W'(xr_q) * K_Q16 + RND_Q16;
    assign mag  = prod >>> 16;
`else
    localparam int SCL_W = XW;
    logic signed [SCL_W-1:0] mag;
    assign mag = xr_q;
`endif

    localparam logic signed [SCL_W-1:0] MOD_MAX = SCL_W'({1'b0, {(DATA_W-1){1'b1}}});

    always_comb begin
        mod_sat = mag[DATA_W-1:0];
        if (mag > MOD_MAX) begin
            mod_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (mag[SCL_W-1]) begin
            // xr never goes negative after the fold; clamp defensively.
            mod_sat = '0;
        end
    end

    // ---------------------------------------------------------------
    // Next-state / datapath
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        zr_d    = zr_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mod_d   = mod_q;
        angle_d = angle_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    // Left half-plane inputs are rotated by 180 degrees so the
                    // CORDIC only has to cover (-90, +90).
                    if (!bus.x_i[DATA_W-1]) begin
                        xr_d = x_ext;
                        yr_d = y_ext;
                        zr_d = '0;
                    end else begin
                        xr_d = -x_ext;
                        yr_d = -y_ext;
                        zr_d = bus.y_i[DATA_W-1] ? -Z180 : Z180;
                    end
                    // With yr stuck at 0 the sign test would keep adding atan
                    // terms; remember the origin so the angle is reported as 0.
                    zero_d  = (bus.x_i == '0) && (bus.y_i == '0);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                if (yr_q[XW-1]) begin
                    xr_d = xr_q - (yr_q >>> cnt_q);
                    yr_d = yr_q + (xr_q >>> cnt_q);
                    zr_d = zr_q - atan_cur;
                end else begin
                    xr_d = xr_q + (yr_q >>> cnt_q);
                    yr_d = yr_q - (xr_q >>> cnt_q);
                    zr_d = zr_q + atan_cur;
                end
                if (cnt_q == CNT_W'(N_ITER - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SCALE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SCALE: begin
                mod_d   = mod_sat;
                angle_d = zero_q ? '0 : zr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers; enable_i low holds everything, including done.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mod_q   <= '0;
            angle_q <= '0;
        end else if (bus.enable_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            zr_q    <= zr_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mod_q   <= mod_d;
            angle_q <= angle_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.mod_o   = mod_q;
    assign bus.angle_o = angle_q;

endmodule

// File: tb/tb_rec2pol_fq.sv
// tb_rec2pol_fq: directed, self-checking bench for rec2pol_fq (default parameters).
// Vector table covers all quadrants, axes, the origin and modulus saturation;
// hand sequences cover ignored starts, enable stalls, done hold, back-to-back and async reset.
module tb_rec2pol_fq;

    localparam int DATA_W     = 32;
    localparam int FRAC_W     = 16;
    localparam int ANGLE_W    = 32;
    localparam int ANGLE_FRAC = 23;
    localparam int N_ITER     = 24;
    localparam int LAT        = N_ITER + 1;

    // Product of sqrt(1+2^-2i), i=0..23.
    localparam real RAW_GAIN = 1.6467602581210656;
`ifdef REC2POL_GAINCOMP_EN
    localparam real MOD_SCALE = RAW_GAIN * 39797.0 / 65536.0;
`else
    localparam real MOD_SCALE = RAW_GAIN;
`endif
    // The angle resolution is limited by the data LSB relative to the modulus
    // (late micro-rotations shift xr to zero), so angle tolerance is in the
    // thousands of ANGLE_FRAC LSBs (~0.004 deg); modulus tolerance is a few
    // tens of LSBs for accumulated truncation.
    localparam longint MOD_TOL = 32;
    localparam longint ANG_TOL = 32768;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rec2pol_fq_if #(.DATA_W(DATA_W), .ANGLE_W(ANGLE_W)) bus ();

    rec2pol_fq #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ANGLE_W(ANGLE_W),
        .ANGLE_FRAC(ANGLE_FRAC), .N_ITER(N_ITER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        real x;
        real y;
        real mag;
        real deg;
        bit  sat;
    } vec_t;

    vec_t vq[$];

    function automatic logic signed [DATA_W-1:0] to_q(input real v);
        return DATA_W'(longint'(v * real'(longint'(1) << FRAC_W)));
    endfunction

    function automatic longint exp_mod(input real mag);
        return longint'(mag * real'(longint'(1) << FRAC_W) * MOD_SCALE);
    endfunction

    function automatic longint exp_ang(input real deg);
        return longint'(deg * real'(longint'(1) << ANGLE_FRAC));
    endfunction

    task automatic add_vec(input real x, input real y, input real mag, input real deg, input bit sat);
        vec_t v;
        v.x = x; v.y = y; v.mag = mag; v.deg = deg; v.sat = sat;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        total++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Issue a start from the idle state and count clock edges until done.
    // enable_i is dropped for dis_len edges once dis_at edges have elapsed.
    task automatic run_conv(input logic signed [DATA_W-1:0] xv, input logic signed [DATA_W-1:0] yv,
                            input int dis_at, input int dis_len, output int lat);
        bus.x_i     = xv;
        bus.y_i     = yv;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk("busy_after_start", longint'(bus.busy_o), 1);
        lat = 0;
        while (!bus.done_o && lat < 200) begin
            bus.enable_i = !(lat >= dis_at && lat < dis_at + dis_len);
            @(posedge clk); #1;
            lat++;
        end
        bus.enable_i = 1'b1;
        chk("done_seen", longint'(bus.done_o), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;
        int first;
        longint m1, a1;

        add_vec(  3.0,  4.0, 5.0,                 53.13010235415598,  1'b0);
        add_vec( -1.0,  1.0, 1.4142135623730951, 135.0,               1'b0);
        add_vec( -1.0, -1.0, 1.4142135623730951, -135.0,              1'b0);
        add_vec( -5.0,  0.0, 5.0,                 180.0,              1'b0);
        add_vec(  0.0,  0.0, 0.0,                 0.0,                1'b0);
        add_vec(  2.0, -2.0, 2.8284271247461903, -45.0,               1'b0);
        add_vec(  0.0,  7.0, 7.0,                 90.0,               1'b0);
        add_vec(  0.0, -3.0, 3.0,                -90.0,               1'b0);
        add_vec( -3.0, -4.0, 5.0,               -126.86989764584402,  1'b0);
        add_vec( -4.0,  3.0, 5.0,                143.13010235415598,  1'b0);
        add_vec( 10.0,  0.0, 10.0,                0.0,                1'b0);
        add_vec(-32768.0, 0.0, 32768.0,         180.0,                1'b1);

        rst          = 1'b1;
        bus.enable_i = 1'b1;
        bus.start_i  = 1'b0;
        bus.x_i      = '0;
        bus.y_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",  longint'(bus.busy_o), 0);
        chk("reset_done",  longint'(bus.done_o), 0);
        chk("reset_mod",   longint'(bus.mod_o), 0);
        chk("reset_angle", longint'(bus.angle_o), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- table-driven vectors ----
        for (int i = 0; i < vq.size(); i++) begin
            run_conv(to_q(vq[i].x), to_q(vq[i].y), 0, 0, lat);
            chk($sformatf("latency[%0d]", i), lat, LAT);
            chk($sformatf("busy_at_done[%0d]", i), longint'(bus.busy_o), 0);
            if (vq[i].sat)
                chk($sformatf("mod_sat[%0d]", i), longint'(bus.mod_o), 64'h7FFF_FFFF);
            else if (vq[i].mag == 0.0)
                chk($sformatf("mod_zero[%0d]", i), longint'(bus.mod_o), 0);
            else
                chk_tol($sformatf("mod[%0d]", i), longint'(bus.mod_o), exp_mod(vq[i].mag), MOD_TOL);
            if (vq[i].mag == 0.0)
                chk($sformatf("angle_zero[%0d]", i), longint'(bus.angle_o), 0);
            else
                chk_tol($sformatf("angle[%0d]", i), longint'(bus.angle_o), exp_ang(vq[i].deg), ANG_TOL);
            @(posedge clk); #1;
            chk($sformatf("done_pulse[%0d]", i), longint'(bus.done_o), 0);
        end

        // ---- starts while busy are ignored ----
        bus.x_i = to_q(3.0); bus.y_i = to_q(4.0); bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        ndone = 0; first = -1; m1 = 0; a1 = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 3 || c == 10) begin
                bus.start_i = 1'b1; bus.x_i = to_q(-5.0); bus.y_i = to_q(0.0);
            end else begin
                bus.start_i = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done_o) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    m1 = longint'(bus.mod_o);
                    a1 = longint'(bus.angle_o);
                end
            end
        end
        bus.start_i = 1'b0;
        chk("ignore_done_count", ndone, 1);
        chk("ignore_latency", first, LAT);
        chk_tol("ignore_mod", m1, exp_mod(5.0), MOD_TOL);
        chk_tol("ignore_angle", a1, exp_ang(53.13010235415598), ANG_TOL);

        // ---- enable low for 5 cycles mid-ITER stretches latency ----
        run_conv(to_q(3.0), to_q(4.0), 8, 5, lat);
        chk("stall_latency", lat, LAT + 5);
        chk_tol("stall_mod", longint'(bus.mod_o), exp_mod(5.0), MOD_TOL);
        chk_tol("stall_angle", longint'(bus.angle_o), exp_ang(53.13010235415598), ANG_TOL);

        // ---- done held while enable is low ----
        bus.enable_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", longint'(bus.done_o), 1);
        bus.enable_i = 1'b1;
        @(posedge clk); #1;
        chk("done_release", longint'(bus.done_o), 0);

        // ---- back-to-back: new start accepted in the done cycle ----
        run_conv(to_q(-4.0), to_q(3.0), 0, 0, lat);
        chk("b2b_first_latency", lat, LAT);
        run_conv(to_q(2.0), to_q(-2.0), 0, 0, lat);
        chk("b2b_second_latency", lat, LAT);
        chk_tol("b2b_mod", longint'(bus.mod_o), exp_mod(2.8284271247461903), MOD_TOL);
        chk_tol("b2b_angle", longint'(bus.angle_o), exp_ang(-45.0), ANG_TOL);
        @(posedge clk); #1;

        // ---- asynchronous reset mid-ITER ----
        bus.x_i = to_q(-1.0); bus.y_i = to_q(1.0); bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy",  longint'(bus.busy_o), 0);
        chk("arst_done",  longint'(bus.done_o), 0);
        chk("arst_mod",   longint'(bus.mod_o), 0);
        chk("arst_angle", longint'(bus.angle_o), 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_conv(to_q(3.0), to_q(4.0), 0, 0, lat);
        chk("post_rst_latency", lat, LAT);
        chk_tol("post_rst_mod", longint'(bus.mod_o), exp_mod(5.0), MOD_TOL);
        chk_tol("post_rst_angle", longint'(bus.angle_o), exp_ang(53.13010235415598), ANG_TOL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
